// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one multiply-accumulate unit between NUM_REQ
// 2-phase producers; emits a sum every VEC_LEN products. Optional MAC_SCHED_SRC_EN adds r_src.
module mac_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4,
  parameter int VEC_LEN = 2,
  parameter int ACC_W   = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        l_req,
  output logic [NUM_REQ-1:0]        l_ack,
  input  logic [NUM_REQ*DATA_W-1:0] l_w_data,
  input  logic [NUM_REQ*DATA_W-1:0] l_i_data,
  output logic                      r_req,
  input  logic                      r_ack,
  output logic [ACC_W-1:0]          r_data
`ifdef MAC_SCHED_SRC_EN
  ,
  output logic [NUM_REQ-1:0]        r_src
`endif
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN + 1) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;

  logic [NUM_REQ-1:0] pending;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [PTR_W-1:0]   rr_nxt;
  logic               last_grant;
  logic [DATA_W-1:0]  w_sel;
  logic [DATA_W-1:0]  i_sel;
  logic [PROD_W-1:0]  product;
  logic [ACC_W-1:0]   sum;

  assign pending = l_req ^ l_ack;

  // Search from rr_ptr upward; the first pending producer wins. Nothing is
  // granted while a result is waiting for its acknowledge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    if (state == COLLECT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_vld && pending[(int'(rr_ptr) + k) % NUM_REQ]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
          grant_oh[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  assign w_sel      = l_w_data[grant_idx*DATA_W +: DATA_W];
  assign i_sel      = l_i_data[grant_idx*DATA_W +: DATA_W];
  assign product    = PROD_W'(w_sel) * PROD_W'(i_sel);
  assign sum        = acc + ACC_W'(product);
  assign last_grant = (cnt == CNT_W'(VEC_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (grant_vld && last_grant) state_nxt = EMIT;
      EMIT:    if (r_ack == r_req)          state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Datapath: one grant per edge at most; an idle cycle holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      l_ack  <= '0;
      r_req  <= 1'b0;
      r_data <= '0;
      acc    <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else if (grant_vld) begin
      l_ack  <= l_ack ^ grant_oh;
      rr_ptr <= rr_nxt;
      if (last_grant) begin
        r_data <= sum;
        r_req  <= ~r_req;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        acc    <= sum;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef MAC_SCHED_SRC_EN
  logic [NUM_REQ-1:0] src_mask;

  // Mask of producers contributing to the result under construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_mask <= '0;
      r_src    <= '0;
    end else if (grant_vld) begin
      if (last_grant) begin
        r_src    <= src_mask | grant_oh;
        src_mask <= '0;
      end else begin
        src_mask <= src_mask | grant_oh;
      end
    end
  end
`endif

endmodule

// File: doc/mac_sched.md
Name: mac_sched

Overview:
- Clocked scheduler that shares one multiply-accumulate resource between NUM_REQ operand producers.
- Each producer offers a (weight, input) pair on a 2-phase req/ack channel.
- A round-robin arbiter grants one pair per cycle. The granted product is added into an accumulator.
- After VEC_LEN products, the sum is emitted on a 2-phase output channel toward a consumer such as a data bucket or sum stage.

Parameters:
- NUM_REQ, 2, number of operand producers (2..8).
- DATA_W, 4, width of the weight and input operands.
- VEC_LEN, 2, products accumulated per result (1..255).
- ACC_W, 9, accumulator/result width; must be >= 2*DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- l_req  in  NUM_REQ  2-phase request per producer; producer i is pending when l_req[i] != l_ack[i].
- l_ack  out  NUM_REQ  2-phase acknowledge per producer.
- l_w_data  in  NUM_REQ*DATA_W  weight operand; producer i occupies bits [i*DATA_W +: DATA_W].
- l_i_data  in  NUM_REQ*DATA_W  input operand; same packing as l_w_data.
- r_req  out  1  2-phase result request.
- r_ack  in  1  2-phase result acknowledge.
- r_data  out  ACC_W  accumulated result.

Behaviour:
- Clock, reset and input timing:
  - One clock. Reset is asynchronous and active-high.
  - All inputs are synchronous to clk; synchronizers are external.
- Reset values:
  - l_ack=0, r_req=0, r_data=0.
  - Internal: acc=0, cnt=0, rr_ptr=0, state=COLLECT.
- State COLLECT:
  - Each cycle, grant the first pending producer found by searching from rr_ptr upward, modulo NUM_REQ.
  - On a grant to producer g at a clock edge:
    - l_ack[g] toggles.
    - acc <= acc + w_g*i_g. Unsigned arithmetic; truncate to ACC_W and wrap, with no saturation.
    - cnt increments.
    - rr_ptr <= (g+1) mod NUM_REQ.
  - At most one grant per cycle. Latency from a sampled pending request to its l_ack toggle is 1 edge.
  - When the grant is the VEC_LEN-th, at that same edge:
    - r_data <= acc + product.
    - r_req toggles.
    - acc <= 0, cnt <= 0.
    - state <= EMIT.
  - No grant in a cycle: all registers hold.
- State EMIT:
  - No grants are issued; pending producers keep waiting.
  - r_data stays stable.
  - When r_ack == r_req is sampled: state <= COLLECT, with no grant issued in that cycle. Grants resume the next cycle.
  - Minimum result-to-next-grant gap is 1 idle cycle.
- Handshake rules:
  - Operands are sampled only on the granting edge. A producer may change its data only after it sees its ack toggle.
  - A producer may supply any number of the VEC_LEN products, including all of them.
- VEC_LEN=1: every grant goes directly to EMIT.
- Simultaneous pending producers are served strictly round-robin, so no producer waits more than NUM_REQ-1 grants.
- Reset mid-operation:
  - The partial accumulation and any unacknowledged result are discarded.
  - A producer whose l_req=1 at reset is pending again after reset, because l_ack=0. It is served again, which is the intended replay behaviour.
- Any r_ack toggle received while in COLLECT is ignored.

Optional Feature:
- Macro: MAC_SCHED_SRC_EN.
- Defined:
  - Adds output r_src [NUM_REQ-1:0]. It is the OR-mask of the producers granted during the current result.
  - r_src is registered with r_data at the emitting edge, held through EMIT, and reset to 0.
  - The internal mask clears when the result is emitted.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with both producers idle, then producer 0 offers (w=3,i=5) and producer 1 offers (w=2,i=7) in the same cycle:
  - l_ack[0] toggles on the first edge and l_ack[1] on the next.
  - r_req toggles with r_data=29.
  - With MAC_SCHED_SRC_EN, r_src=2'b11.
- Max values, with producer 0 supplying both products (15,15) and (15,15):
  - r_data=450, no wrap.
  - Repeat with VEC_LEN=3, ACC_W=9: r_data=675 mod 512=163.
- Result back-pressure, r_ack withheld 10 cycles while both producers pending:
  - No l_ack toggles and r_data stable during EMIT.
  - After r_ack toggles, exactly 1 idle cycle, then a grant to the producer following the last granted one.
- Continuous pending on both producers for 8 grants:
  - Grant order 0,1,0,1,...
  - 4 results emitted, each equal to that pair's dot product.
- Assert rst after 1 of 2 products, with l_req[0]=1 and l_ack[0]=1:
  - Outputs are 0 immediately, before any clock edge.
  - Producer 0 is re-served after release.
  - The first result excludes the pre-reset product.
- VEC_LEN=1 (w=4,i=4):
  - Single grant, r_data=16, r_req toggles on the same edge as l_ack.
